// File: rtl/haraka512_digest_out.sv
// Haraka-512 output stage: feed-forward XOR, truncation to a 256-bit digest,
// and serialization of that digest as NW words of WORD_W bits.
module haraka512_digest_out #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [511:0]      perm_out,
  input  logic [511:0]      msg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       digest_cnt
);
  localparam int NW = 256 / WORD_W;
  localparam int BW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NW - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt;
  logic [BW-1:0] beat_r;
  logic [BW-1:0] beat_nxt;
  logic [255:0]  digest_r;
  logic [255:0]  digest_in;
  logic [255:0]  digest_shift;
  logic [511:0]  ff_full;
  logic [15:0]   cnt_r;
  logic          out_fire;
  logic          last_fire;
  logic          in_fire;
  logic          unused_ff_bytes;

  // Feed-forward and truncation: keep F bytes 8..15, 24..31, 32..39, 48..55.
  always_comb begin
    ff_full         = perm_out ^ msg_in;
    digest_in       = {ff_full[447:384], ff_full[319:256], ff_full[255:192], ff_full[127:64]};
    unused_ff_bytes = ^{ff_full[511:448], ff_full[383:320], ff_full[191:128], ff_full[63:0]};
  end

  // Handshake decode and word selection from the holding register.
  always_comb begin
    out_valid    = (state_r == SEND);
    busy         = (state_r == SEND);
    out_last     = out_valid && (beat_r == LAST_BEAT);
    out_fire     = out_valid && out_ready;
    last_fire    = out_fire && out_last;
    in_ready     = (state_r == IDLE) || last_fire;
    in_fire      = in_valid && in_ready;
    digest_shift = digest_r << (32'(beat_r) * WORD_W);
    out_data     = digest_shift[255 -: WORD_W];
  end

  // Next state and beat index; a new digest accepted on the last beat restarts at beat 0.
  always_comb begin
    state_nxt = state_r;
    beat_nxt  = beat_r;
    case (state_r)
      IDLE: begin
        if (in_fire) state_nxt = SEND;
        else         state_nxt = IDLE;
      end
      SEND: begin
        if (last_fire && !in_fire) state_nxt = IDLE;
        else                       state_nxt = SEND;
      end
      default: state_nxt = IDLE;
    endcase
    if (in_fire || last_fire) beat_nxt = {BW{1'b0}};
    else if (out_fire)        beat_nxt = beat_r + BW'(1);
    else                      beat_nxt = beat_r;
  end

  // State, beat, digest holding register and completed-digest counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      beat_r   <= {BW{1'b0}};
      digest_r <= 256'd0;
      cnt_r    <= 16'd0;
    end else begin
      state_r <= state_nxt;
      beat_r  <= beat_nxt;
      if (in_fire)   digest_r <= digest_in;
      if (last_fire) cnt_r    <= cnt_r + 16'd1;
    end
  end

  assign digest_cnt = cnt_r;

endmodule

// File: tb/tb_haraka512_digest_out.sv
// Scoreboard bench for haraka512_digest_out: a 32-bit-word instance and a 256-bit-word instance.
module tb_haraka512_digest_out;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] perm;
  logic [511:0] msg;

  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a, busy_a;
  logic [31:0]  out_data_a;
  logic [15:0]  cnt_a;
  logic         in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_last_w, busy_w;
  logic [255:0] out_data_w;
  logic [15:0]  cnt_w;

  typedef struct packed {
    logic [255:0] data;
    logic         last;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_w[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt_a = 16'd0;
  logic [15:0] exp_cnt_w = 16'd0;

  localparam logic [255:0] BASIC_D =
    256'h08090A0B_0C0D0E0F_18191A1B_1C1D1E1F_20212223_24252627_30313233_34353637;

  haraka512_digest_out #(.WORD_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .perm_out(perm), .msg_in(msg), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_last(out_last_a), .busy(busy_a), .digest_cnt(cnt_a)
  );

  haraka512_digest_out #(.WORD_W(256)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .perm_out(perm), .msg_in(msg), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .out_data(out_data_w), .out_last(out_last_w), .busy(busy_w), .digest_cnt(cnt_w)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] msg_seq();
    logic [511:0] m;
    for (int i = 0; i < 64; i++) m[511 - 8*i -: 8] = 8'(i);
    return m;
  endfunction

  // Reference digest built byte by byte from the list of kept byte positions.
  function automatic logic [255:0] model_digest(input logic [511:0] p, input logic [511:0] m);
    logic [255:0] d;
    int src;
    for (int j = 0; j < 32; j++) begin
      if (j < 8)       src = 8 + j;
      else if (j < 16) src = 24 + (j - 8);
      else if (j < 24) src = 32 + (j - 16);
      else             src = 48 + (j - 24);
      d[255 - 8*j -: 8] = p[511 - 8*src -: 8] ^ m[511 - 8*src -: 8];
    end
    return d;
  endfunction

  task automatic push_a(input logic [255:0] d);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.data = {224'd0, d[255 - 32*k -: 32]};
      e.last = (k == 7);
      q_a.push_back(e);
    end
  endtask

  task automatic push_w(input logic [255:0] d);
    exp_t e;
    e.data = d;
    e.last = 1'b1;
    q_w.push_back(e);
  endtask

  // Scoreboard for the 32-bit instance: every accepted beat is checked against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid_a && out_ready_a) begin
      n_checks++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL sb_a_unexpected: got beat %h last=%b, expected no beat", out_data_a, out_last_a);
      end else begin
        e = q_a.pop_front();
        if (out_data_a !== e.data[31:0] || out_last_a !== e.last) begin
          n_fail++;
          $display("FAIL sb_a_beat: got %h last=%b, expected %h last=%b",
                   out_data_a, out_last_a, e.data[31:0], e.last);
        end
      end
    end
  end

  // Scoreboard for the 256-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid_w && out_ready_w) begin
      n_checks++;
      if (q_w.size() == 0) begin
        n_fail++;
        $display("FAIL sb_w_unexpected: got beat %h, expected no beat", out_data_w);
      end else begin
        e = q_w.pop_front();
        if (out_data_w !== e.data || out_last_w !== e.last) begin
          n_fail++;
          $display("FAIL sb_w_beat: got %h last=%b, expected %h last=%b",
                   out_data_w, out_last_w, e.data, e.last);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({out_valid_a, out_last_a, busy_a, in_ready_a} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_ctrl_a: got %b, expected 0001", {out_valid_a, out_last_a, busy_a, in_ready_a});
    end
    n_checks++;
    if (out_data_a !== 32'd0 || cnt_a !== 16'd0) begin
      n_fail++; $display("FAIL reset_data_a: got data=%h cnt=%h, expected 0 and 0", out_data_a, cnt_a);
    end
    n_checks++;
    if ({out_valid_w, out_last_w, busy_w, in_ready_w} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_ctrl_w: got %b, expected 0001", {out_valid_w, out_last_w, busy_w, in_ready_w});
    end
    n_checks++;
    if (out_data_w !== 256'd0 || cnt_w !== 16'd0) begin
      n_fail++; $display("FAIL reset_data_w: got data=%h cnt=%h, expected 0 and 0", out_data_w, cnt_w);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_basic();
    int acc_at = -1;
    int beats = 0;
    perm = 512'd0; msg = msg_seq(); in_valid_a = 1'b1; out_ready_a = 1'b1;
    for (int i = 0; i < 40 && beats < 8; i++) begin
      @(negedge clk);
      if (acc_at >= 0 && i == acc_at + 1) begin
        n_checks++;
        if (out_valid_a !== 1'b1 || busy_a !== 1'b1) begin
          n_fail++; $display("FAIL basic_latency: got valid=%b busy=%b one cycle after accept, expected 1 1", out_valid_a, busy_a);
        end
      end
      if (out_valid_a && out_ready_a) beats++;
      if (in_valid_a && in_ready_a) begin push_a(BASIC_D); exp_cnt_a++; acc_at = i; end
      @(posedge clk); #2;
      if (acc_at >= 0) in_valid_a = 1'b0;
    end
    n_checks++;
    if (beats != 8 || q_a.size() != 0) begin
      n_fail++; $display("FAIL basic_beats: got %0d beats (%0d pending), expected 8 (0 pending)", beats, q_a.size());
    end
    n_checks++;
    if (cnt_a !== 16'd1 || out_valid_a !== 1'b0) begin
      n_fail++; $display("FAIL basic_cnt: got cnt=%h valid=%b, expected 0001 0", cnt_a, out_valid_a);
    end
  endtask

  task automatic test_feedforward();
    int acc = 0;
    int beats = 0;
    perm = {64{8'hFF}}; msg = {64{8'h0F}}; in_valid_a = 1'b1; out_ready_a = 1'b1;
    for (int i = 0; i < 40 && beats < 8; i++) begin
      @(negedge clk);
      if (out_valid_a && out_ready_a) beats++;
      if (in_valid_a && in_ready_a) begin push_a({32{8'hF0}}); exp_cnt_a++; acc++; end
      @(posedge clk); #2;
      if (acc > 0) in_valid_a = 1'b0;
    end
    n_checks++;
    if (beats != 8 || cnt_a !== exp_cnt_a) begin
      n_fail++; $display("FAIL ff_done: got %0d beats cnt=%h, expected 8 beats cnt=%h", beats, cnt_a, exp_cnt_a);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int beats = 0;
    logic prev_stall = 1'b0;
    logic [32:0] prev = 33'd0;
    perm = 512'd0; msg = msg_seq(); in_valid_a = 1'b1; out_ready_a = 1'b0;
    for (int i = 0; i < 300 && beats < 8; i++) begin
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if ({out_last_a, out_data_a} !== prev || out_valid_a !== 1'b1) begin
          n_fail++; $display("FAIL bp_stable: got valid=%b last/data=%h, expected 1 %h", out_valid_a, {out_last_a, out_data_a}, prev);
        end
      end
      if (acc > 0 && out_valid_a) begin
        n_checks++;
        if (in_ready_a !== (out_ready_a & out_last_a)) begin
          n_fail++; $display("FAIL bp_in_ready: got %b, expected %b", in_ready_a, out_ready_a & out_last_a);
        end
      end
      prev_stall = out_valid_a && !out_ready_a;
      prev = {out_last_a, out_data_a};
      if (out_valid_a && out_ready_a) beats++;
      if (acc == 0 && in_valid_a && in_ready_a) begin push_a(model_digest(perm, msg)); exp_cnt_a++; acc++; end
      @(posedge clk); #2;
      out_ready_a = 1'($urandom_range(0, 1));
      if (acc == 0) in_valid_a = 1'b1;
      else if (beats < 8) begin
        in_valid_a = !out_ready_a;
        perm = {16{$urandom()}};
      end else in_valid_a = 1'b0;
    end
    in_valid_a = 1'b0; out_ready_a = 1'b1;
    n_checks++;
    if (beats != 8) begin
      n_fail++; $display("FAIL bp_timeout: got %0d beats, expected 8", beats);
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int beats = 0;
    int gaps = 0;
    logic [15:0] cnt0;
    cnt0 = exp_cnt_a;
    perm = {16{$urandom()}}; msg = msg_seq(); in_valid_a = 1'b1; out_ready_a = 1'b1;
    for (int i = 0; i < 60 && beats < 16; i++) begin
      @(negedge clk);
      if (beats > 0 && !out_valid_a) gaps++;
      if (out_valid_a && out_ready_a) beats++;
      if (in_valid_a && in_ready_a) begin
        push_a(model_digest(perm, msg)); exp_cnt_a++; acc++;
        if (acc == 2) begin
          n_checks++;
          if (out_last_a !== 1'b1) begin
            n_fail++; $display("FAIL b2b_overlap: second accept with out_last=%b, expected 1", out_last_a);
          end
        end
      end
      @(posedge clk); #2;
      if (acc == 1) begin perm = {16{$urandom()}}; msg = ~msg_seq(); end
      else if (acc >= 2) in_valid_a = 1'b0;
    end
    n_checks++;
    if (beats != 16 || gaps != 0) begin
      n_fail++; $display("FAIL b2b_stream: got %0d beats %0d gaps, expected 16 beats 0 gaps", beats, gaps);
    end
    n_checks++;
    if (cnt_a !== cnt0 + 16'd2) begin
      n_fail++; $display("FAIL b2b_cnt: got %h, expected %h", cnt_a, cnt0 + 16'd2);
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    int beats = 0;
    int stale = 0;
    perm = 512'd0; msg = msg_seq(); in_valid_a = 1'b1; out_ready_a = 1'b1;
    for (int i = 0; i < 40 && beats < 3; i++) begin
      @(negedge clk);
      if (out_valid_a && out_ready_a) beats++;
      if (in_valid_a && in_ready_a) begin push_a(BASIC_D); exp_cnt_a++; acc++; end
      if (beats < 3) begin
        @(posedge clk); #2;
        if (acc > 0) in_valid_a = 1'b0;
      end
    end
    @(posedge clk); #2;
    n_checks++;
    if (out_valid_a !== 1'b1 || beats != 3) begin
      n_fail++; $display("FAIL rmid_pre: got valid=%b after %0d beats, expected 1 after 3", out_valid_a, beats);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid_a, out_last_a, busy_a, in_ready_a} !== 4'b0001 || out_data_a !== 32'd0) begin
      n_fail++; $display("FAIL rmid_ctrl: got %b data=%h, expected 0001 data=0", {out_valid_a, out_last_a, busy_a, in_ready_a}, out_data_a);
    end
    n_checks++;
    if (cnt_a !== 16'd0 || cnt_w !== 16'd0) begin
      n_fail++; $display("FAIL rmid_cnt: got %h %h, expected 0000 0000", cnt_a, cnt_w);
    end
    q_a.delete(); exp_cnt_a = 16'd0; exp_cnt_w = 16'd0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid_a) stale++;
    end
    n_checks++;
    if (stale != 0) begin
      n_fail++; $display("FAIL rmid_stale: got %0d stale valid cycles, expected 0", stale);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_wide();
    int acc = 0;
    int beats = 0;
    perm = 512'd0; msg = msg_seq(); in_valid_w = 1'b1; out_ready_w = 1'b1;
    for (int i = 0; i < 20 && beats < 1; i++) begin
      @(negedge clk);
      if (out_valid_w && out_ready_w) begin
        beats++;
        n_checks++;
        if (out_last_w !== 1'b1) begin
          n_fail++; $display("FAIL wide_last: got %b, expected 1", out_last_w);
        end
      end
      if (in_valid_w && in_ready_w) begin push_w(BASIC_D); exp_cnt_w++; acc++; end
      @(posedge clk); #2;
      if (acc > 0) in_valid_w = 1'b0;
    end
    n_checks++;
    if (beats != 1 || cnt_w !== 16'd1) begin
      n_fail++; $display("FAIL wide_done: got %0d beats cnt=%h, expected 1 beat cnt=0001", beats, cnt_w);
    end
  endtask

  task automatic test_wrap();
    logic [255:0] d;
    int target;
    int acc;
    int done;
    perm = {16{32'hA5C3_0F96}}; msg = msg_seq(); out_ready_w = 1'b1;
    d = model_digest(perm, msg);
    for (int phase = 0; phase < 2; phase++) begin
      target = (phase == 0) ? int'(16'hFFFF - exp_cnt_w) : 1;
      acc = 0; done = 0;
      in_valid_w = 1'b1;
      for (int i = 0; i < target + 20 && done < target; i++) begin
        @(negedge clk);
        if (out_valid_w && out_ready_w) done++;
        if (in_valid_w && in_ready_w) begin push_w(d); exp_cnt_w++; acc++; end
        @(posedge clk); #2;
        in_valid_w = (acc < target);
      end
      in_valid_w = 1'b0;
      n_checks++;
      if (done != target || cnt_w !== ((phase == 0) ? 16'hFFFF : 16'h0000)) begin
        n_fail++; $display("FAIL wrap_phase%0d: got %0d digests cnt=%h, expected %0d digests cnt=%h",
                           phase, done, cnt_w, target, (phase == 0) ? 16'hFFFF : 16'h0000);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; perm = 512'd0; msg = 512'd0;
    in_valid_a = 1'b0; out_ready_a = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b0;
    test_reset();
    test_basic();
    test_feedforward();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    test_wrap();
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q_a.size() != 0 || q_w.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d/%0d pending beats, expected 0/0", q_a.size(), q_w.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
